ifid_queue: RTL
===============

IFID_QUEUE -- requirements
Module: ifid_queue

Interface
REQ-001 Parameter INST_W, default 32, instruction word width.
REQ-002 Parameter ADDR_W, default 32, PC address width.
REQ-003 Parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-004 Parameter DROP_CYCLES, default 1, post-flush cycles during which fetch beats are discarded; 0 disables dropping.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  fetch stage presents a beat.
REQ-008 in_ready  output  1  queue can accept a beat this cycle.
REQ-009 in_inst  input  INST_W  fetched instruction.
REQ-010 in_pc  input  ADDR_W  PC of fetched instruction.
REQ-011 out_valid  output  1  head entry valid to decode.
REQ-012 out_ready  input  1  decode consumes head this cycle; low = full stall.
REQ-013 out_inst  output  INST_W  head instruction; 0 when out_valid=0.
REQ-014 out_pc  output  ADDR_W  head PC; 0 when out_valid=0.
REQ-015 flush  input  1  jump/branch redirect; discard all contents.
REQ-016 count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-017 Storage: circular buffer of DEPTH {inst, pc} entries; read/write pointers carry one extra wrap bit; full = pointers equal except wrap bit; empty = pointers fully equal.
REQ-018 in_ready = (count < DEPTH) || (drop_cnt != 0); combinational from registered state only, independent of in_valid.
REQ-019 out_valid = (count != 0); out_inst/out_pc driven from head entry, forced to 0 (bubble) when empty.
REQ-020 push = in_valid && in_ready && !flush && drop_cnt == 0; writes entry at write pointer, advances it.
REQ-021 pop = out_valid && out_ready && !flush; advances read pointer.
REQ-022 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-023 Full: in_ready=0 (when drop_cnt=0) even if a pop occurs the same cycle; no same-cycle bypass of freed slot.
REQ-024 Empty: no write-through bypass; pushed beat appears on out_valid one cycle after the accepting edge (latency 1).
REQ-025 Pointer wrap: index bits wrap DEPTH-1 -> 0; wrap bit toggles; no entry lost or duplicated across wrap.
REQ-026 flush: at next edge pointers and count -> 0, drop_cnt -> DROP_CYCLES; flush overrides any same-cycle push or pop.
REQ-027 Drop window: while drop_cnt != 0, in_ready=1, any in_valid beat is accepted and discarded; drop_cnt decrements by 1 every cycle regardless of in_valid.
REQ-028 flush asserted during drop window reloads drop_cnt to DROP_CYCLES.
REQ-029 Flush held multiple cycles: queue stays empty, drop_cnt held at DROP_CYCLES until flush deasserts.
REQ-030 out_ready low holds head entry and outputs stable indefinitely; no entry modified while not popped.
REQ-031 No latches; no logic on negedge or on data-signal edges; all state clocked by clk only.

Reset
REQ-032 rst asserted: immediately (asynchronously) pointers=0, count=0, drop_cnt=0, out_valid=0, out_inst=0, out_pc=0, in_ready=1.
REQ-033 rst mid-operation discards all entries and any drop window; first edge after deassertion may accept a push.
REQ-034 Storage array contents need not be reset; never observable since outputs are gated by out_valid.

Verification
REQ-035 Fill/drain: DEPTH=4, out_ready=0, push pc 0x100..0x10C -> count=4, in_ready=0; 5th beat ignored; out_ready=1 -> pcs 0x100,0x104,0x108,0x10C in order, then out_valid=0, out_pc=0.
REQ-036 Streaming: in_valid and out_ready high every cycle for 10 beats -> count stays 1 after first beat, one beat out per cycle, pointers wrap twice with correct order.
REQ-037 Flush with drop: count=3, flush one cycle with DROP_CYCLES=1 -> next cycle count=0, out_valid=0; beat offered the following cycle is discarded; beat after that is queued.
REQ-038 Flush vs push/pop: flush, in_valid, out_ready all high on same cycle at count=2 -> count=0, no entry written, nothing emitted.
REQ-039 Async reset mid-stream: rst pulsed between edges at count=3 -> out_valid=0, count=0 before next rising edge; post-reset push pc 0x200 appears one cycle later.
REQ-040 Full with pop: count=4, in_valid=1, out_ready=1 -> in_ready=0, count becomes 3, offered beat accepted only next cycle.

Source files
------------

// File: rtl/ifid_queue.sv
// IF/ID decoupling queue: a circular buffer of {inst, pc} entries between fetch and decode,
// with a flush that empties it and an optional window that discards in-flight fetch beats.
module ifid_queue #(
   parameter int INST_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 4,
   parameter int DROP_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [INST_W-1:0]          in_inst,
   input  logic [ADDR_W-1:0]          in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INST_W-1:0]          out_inst,
   output logic [ADDR_W-1:0]          out_pc,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int PTR_W  = IDX_W + 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int DROP_W = (DROP_CYCLES > 0) ? $clog2(DROP_CYCLES + 1) : 1;
   localparam logic [DROP_W-1:0] DROP_LOAD = DROP_W'(DROP_CYCLES);

   // Handshakes: a beat transfers on an edge where valid and ready are both high.
   // in_ready depends only on registered state, never on in_valid; out_valid never
   // depends on out_ready, so neither side can form a combinational loop.

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic [INST_W-1:0] inst_mem_q [DEPTH];
   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

   logic             empty;
   logic             full;
   logic             dropping;
   logic             push;
   logic             pop;
   logic [PTR_W-1:0] occupancy;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   assign wr_idx    = wr_ptr_q[IDX_W-1:0];
   assign rd_idx    = rd_ptr_q[IDX_W-1:0];
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) && (wr_idx == rd_idx);
   assign dropping  = (drop_cnt_q != '0);
   assign occupancy = wr_ptr_q - rd_ptr_q;
   assign count     = CNT_W'(occupancy);

   assign in_ready  = !full || dropping;
   assign out_valid = !empty;
   assign out_inst  = empty ? '0 : inst_mem_q[rd_idx];
   assign out_pc    = empty ? '0 : pc_mem_q[rd_idx];

   // Beats accepted during the drop window are swallowed: they belong to the redirected path.
   assign push = in_valid && in_ready && !flush && !dropping;
   assign pop  = out_valid && out_ready && !flush;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      drop_cnt_d = drop_cnt_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         drop_cnt_d = DROP_LOAD;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (dropping) begin
            drop_cnt_d = drop_cnt_q - DROP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is never reset; its contents are only visible through the empty gate above.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[wr_idx] <= in_inst;
         pc_mem_q[wr_idx]   <= in_pc;
      end
   end

endmodule
